top_module_pipe: RTL and testbench
==================================

TOP_MODULE_PIPE -- requirements
Module: top_module_pipe

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL provide: resetpc  input  1  run enable; 0 holds PC at 0 and flushes the pipeline, 1 runs.
REQ-004 SHALL provide: we0  input  1  instruction-memory write enable.
REQ-005 SHALL provide: wr_addr0  input  9  byte address of the instruction-memory write; bits [8:2] select one of 128 words.
REQ-006 SHALL provide: wr_din0  input  32  instruction word to write.
REQ-007 SHALL provide: dbg_pc  output  32  current IF-stage PC.
REQ-008 SHALL provide: dbg_wb_we, dbg_wb_rd[4:0], dbg_wb_data[31:0]  outputs  register write-back observed in the WB stage.

Function
REQ-009 SHALL be a 5-stage RV32I-subset pipeline: IF, ID, EX, MEM, WB.
REQ-010 SHALL implement ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU, the matching immediate forms, LUI, LW, SW, BEQ, BNE, BLT, BGE and JAL.
REQ-011 SHALL execute every other opcode as a NOP with no register or memory write.
REQ-012 Instruction memory SHALL be 128x32, written synchronously when we0=1 at word wr_addr0[8:2], and read combinationally at PC[8:2].
REQ-013 Data memory SHALL be a separate 128x32 array, word-addressed by ALU result [8:2], written synchronously in MEM and read combinationally.
REQ-014 Register file SHALL be 32x32 with x0 reading 0 and writes to x0 ignored.
REQ-015 Register file SHALL write in the first half of the cycle, so ID reads the value written by WB in the same cycle.
REQ-016 SHALL forward operands into EX: from EX/MEM first, then MEM/WB, else the register file; a forwarded rd of x0 is never used.
REQ-017 A load-use hazard (EX holds LW and its rd matches ID rs1/rs2, rd!=0) SHALL stall PC and IF/ID for 1 cycle and insert a bubble into ID/EX.
REQ-018 Branch conditions and JAL SHALL resolve in EX; when taken, PC = EX PC + immediate, IF/ID and ID/EX are flushed (2-cycle penalty), and JAL writes PC+4 to rd.
REQ-019 Otherwise PC SHALL increment by 4 each cycle and wrap modulo 512 bytes.
REQ-020 Taken branch and load-use stall in the same cycle: the branch SHALL win.
REQ-021 While resetpc=0, PC SHALL be 0, all pipeline registers SHALL be bubbles, and we0 writes remain allowed.
REQ-022 The first instruction SHALL be fetched from address 0 on the first rising edge after resetpc rises.
REQ-023 A we0 write while running SHALL take effect for fetches in the next cycle.

Reset
REQ-024 reset=1 SHALL immediately set PC=0, all pipeline registers to bubbles (no write enables), all registers to 0, and dbg_wb_we=0.
REQ-025 Instruction and data memory contents SHALL NOT be cleared by reset.
REQ-026 Reset mid-operation SHALL abort all in-flight instructions with no further writes.

Structure
REQ-027 A shared package SHALL hold: opcode constants, ALU-operation enum, immediate-type enum, and memory depth (128) / address width (9).
REQ-028 The register file SHALL be the single sub-module, pipe_regfile; ALU, control, hazard and forwarding logic remain in top_module_pipe.

Verification
REQ-029 Load `addi x1,x0,5; addi x2,x0,7; add x3,x1,x2` at 0,4,8, then raise resetpc -> WB shows x3=12 and back-to-back forwarding is correct.
REQ-030 Run `addi x1,x0,64; sw x1,0(x0); lw x2,0(x0); addi x3,x2,1` -> exactly one stall cycle, and x3=65.
REQ-031 Run `addi x1,x0,1; beq x1,x1,8; addi x2,x0,9; addi x4,x0,3` -> x2 is never written and x4=3.
REQ-032 Run `jal x5,12` at address 0 -> x5=4, the next fetch is at address 12, and 2 bubbles are inserted.
REQ-033 Run `addi x0,x0,5` followed by `add x6,x0,x0` -> x6=0.
REQ-034 Assert reset mid-program -> PC=0 and dbg_wb_we=0 at once, and the program reruns from 0 when reset is released with resetpc=1.

Source files
------------

// File: rtl/top_module_pipe_pkg.sv
// rtl/top_module_pipe_pkg.sv - shared opcodes, enums and stage records for the RV32I-subset pipeline
package top_module_pipe_pkg;

    localparam int MEM_DEPTH = 128;
    localparam int ADDR_W    = 9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    // All-zero encodes a bubble: no register, memory or PC side effects
    typedef struct packed {
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       jal;
        logic       alu_src_imm;
        alu_op_e    alu_op;
        logic [2:0] funct3;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } id_ex_t;

    typedef struct packed {
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  rd;
        logic [31:0] data;
    } mem_wb_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e kind);
        case (kind)
            IMM_I:   imm_gen = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm_gen = {instr[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_gen = 32'b0;
        endcase
    endfunction

    // Register forms honour bit 30 for SUB; immediate forms only for SRAI
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'b000:  alu_decode = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - 32x32 register file with x0 hardwired and write-through reads
module pipe_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];

    // Write port; x0 is never stored so it always reads back zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'b0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    // Read ports pass the WB value straight through so ID sees this cycle's write
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (ra1 == 5'd0) begin
            rd1 = 32'b0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
        if (ra2 == 5'd0) begin
            rd2 = 32'b0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/top_module_pipe.sv
// rtl/top_module_pipe.sv - five-stage RV32I-subset pipeline with forwarding, load-use stall and EX branches
module top_module_pipe
    import top_module_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              resetpc,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [31:0]       wr_din0,
    output logic [31:0]       dbg_pc,
    output logic              dbg_wb_we,
    output logic [4:0]        dbg_wb_rd,
    output logic [31:0]       dbg_wb_data
);

    logic [31:0] imem_q [MEM_DEPTH];
    logic [31:0] dmem_q [MEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [1:0]  unused_wr_addr;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] rf_rd1, rf_rd2;
    ctrl_t       id_ctrl;
    imm_type_e   id_imm_type;
    logic        load_use;
    logic [31:0] ex_a, ex_rs2, ex_b, alu_res, ex_result;
    logic        br_cond, ex_take;
    logic [8:0]  br_target;
    logic [31:0] mem_rdata;

    assign unused_wr_addr = wr_addr0[1:0];
    assign id_rs1 = if_id_q.instr[19:15];
    assign id_rs2 = if_id_q.instr[24:20];

    // Instruction memory load port; contents survive reset
    always_ff @(posedge clk) begin
        if (we0) begin
            imem_q[wr_addr0[8:2]] <= wr_din0;
        end
    end

    // Data memory store in MEM; contents survive reset
    always_ff @(posedge clk) begin
        if (ex_mem_q.mem_we) begin
            dmem_q[ex_mem_q.result[8:2]] <= ex_mem_q.store_data;
        end
    end

    pipe_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (id_rs1),
        .ra2   (id_rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (mem_wb_q.reg_we),
        .wa    (mem_wb_q.rd),
        .wd    (mem_wb_q.data)
    );

    // ID decode; unsupported opcodes and widths fall out as all-zero control (NOP)
    always_comb begin
        id_ctrl     = '0;
        id_imm_type = IMM_NONE;
        case (if_id_q.instr[6:0])
            OP_R: begin
                id_ctrl.reg_we = 1'b1;
                id_ctrl.alu_op = alu_decode(if_id_q.instr[14:12], if_id_q.instr[30], 1'b1);
            end
            OP_IMM: begin
                id_ctrl.reg_we      = 1'b1;
                id_ctrl.alu_src_imm = 1'b1;
                id_ctrl.alu_op      = alu_decode(if_id_q.instr[14:12], if_id_q.instr[30], 1'b0);
                id_imm_type         = IMM_I;
            end
            OP_LUI: begin
                id_ctrl.reg_we      = 1'b1;
                id_ctrl.alu_src_imm = 1'b1;
                id_ctrl.alu_op      = ALU_PASSB;
                id_imm_type         = IMM_U;
            end
            OP_LOAD: begin
                if (if_id_q.instr[14:12] == 3'b010) begin
                    id_ctrl.reg_we      = 1'b1;
                    id_ctrl.mem_re      = 1'b1;
                    id_ctrl.alu_src_imm = 1'b1;
                    id_imm_type         = IMM_I;
                end
            end
            OP_STORE: begin
                if (if_id_q.instr[14:12] == 3'b010) begin
                    id_ctrl.mem_we      = 1'b1;
                    id_ctrl.alu_src_imm = 1'b1;
                    id_imm_type         = IMM_S;
                end
            end
            OP_BRANCH: begin
                if ((if_id_q.instr[13:12] != 2'b11) && (if_id_q.instr[14:13] != 2'b01)
                    && (if_id_q.instr[14:12] != 3'b110)) begin
                    id_ctrl.branch = 1'b1;
                    id_imm_type    = IMM_B;
                end
            end
            OP_JAL: begin
                id_ctrl.reg_we = 1'b1;
                id_ctrl.jal    = 1'b1;
                id_imm_type    = IMM_J;
            end
            default: ;
        endcase
        id_ctrl.funct3 = if_id_q.instr[14:12];
    end

    // Load-use hazard: the loaded value is not available until it reaches WB
    assign load_use = id_ex_q.ctrl.mem_re && (id_ex_q.rd != 5'd0)
                      && ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2));

    // Operand forwarding into EX, youngest producer first, never from x0
    always_comb begin
        ex_a   = id_ex_q.rs1_val;
        ex_rs2 = id_ex_q.rs2_val;
        if (ex_mem_q.reg_we && (ex_mem_q.rd != 5'd0) && (ex_mem_q.rd == id_ex_q.rs1)) begin
            ex_a = ex_mem_q.result;
        end else if (mem_wb_q.reg_we && (mem_wb_q.rd != 5'd0) && (mem_wb_q.rd == id_ex_q.rs1)) begin
            ex_a = mem_wb_q.data;
        end
        if (ex_mem_q.reg_we && (ex_mem_q.rd != 5'd0) && (ex_mem_q.rd == id_ex_q.rs2)) begin
            ex_rs2 = ex_mem_q.result;
        end else if (mem_wb_q.reg_we && (mem_wb_q.rd != 5'd0) && (mem_wb_q.rd == id_ex_q.rs2)) begin
            ex_rs2 = mem_wb_q.data;
        end
    end

    // ALU, branch condition and redirect target
    always_comb begin
        ex_b = id_ex_q.ctrl.alu_src_imm ? id_ex_q.imm : ex_rs2;
        case (id_ex_q.ctrl.alu_op)
            ALU_ADD:   alu_res = ex_a + ex_b;
            ALU_SUB:   alu_res = ex_a - ex_b;
            ALU_AND:   alu_res = ex_a & ex_b;
            ALU_OR:    alu_res = ex_a | ex_b;
            ALU_XOR:   alu_res = ex_a ^ ex_b;
            ALU_SLL:   alu_res = ex_a << ex_b[4:0];
            ALU_SRL:   alu_res = ex_a >> ex_b[4:0];
            ALU_SRA:   alu_res = $signed(ex_a) >>> ex_b[4:0];
            ALU_SLT:   alu_res = {31'b0, $signed(ex_a) < $signed(ex_b)};
            ALU_SLTU:  alu_res = {31'b0, ex_a < ex_b};
            ALU_PASSB: alu_res = ex_b;
            default:   alu_res = 32'b0;
        endcase
        case (id_ex_q.ctrl.funct3)
            3'b000:  br_cond = (ex_a == ex_rs2);
            3'b001:  br_cond = (ex_a != ex_rs2);
            3'b100:  br_cond = ($signed(ex_a) < $signed(ex_rs2));
            3'b101:  br_cond = !($signed(ex_a) < $signed(ex_rs2));
            default: br_cond = 1'b0;
        endcase
        ex_take   = id_ex_q.ctrl.jal || (id_ex_q.ctrl.branch && br_cond);
        br_target = id_ex_q.pc[8:0] + id_ex_q.imm[8:0];
        ex_result = id_ex_q.ctrl.jal ? (id_ex_q.pc + 32'd4) : alu_res;
    end

    assign mem_rdata = dmem_q[ex_mem_q.result[8:2]];

    // Next-state for PC and every stage register, then run/flush/stall overrides
    always_comb begin
        pc_d           = {{(32-ADDR_W){1'b0}}, pc_q[8:0] + 9'd4};
        if_id_d.pc     = pc_q;
        if_id_d.instr  = imem_q[pc_q[8:2]];

        id_ex_d.pc      = if_id_q.pc;
        id_ex_d.rs1_val = rf_rd1;
        id_ex_d.rs2_val = rf_rd2;
        id_ex_d.imm     = imm_gen(if_id_q.instr, id_imm_type);
        id_ex_d.rs1     = id_rs1;
        id_ex_d.rs2     = id_rs2;
        id_ex_d.rd      = if_id_q.instr[11:7];
        id_ex_d.ctrl    = id_ctrl;

        ex_mem_d.reg_we     = id_ex_q.ctrl.reg_we;
        ex_mem_d.mem_re     = id_ex_q.ctrl.mem_re;
        ex_mem_d.mem_we     = id_ex_q.ctrl.mem_we;
        ex_mem_d.rd         = id_ex_q.rd;
        ex_mem_d.result     = ex_result;
        ex_mem_d.store_data = ex_rs2;

        mem_wb_d.reg_we = ex_mem_q.reg_we;
        mem_wb_d.rd     = ex_mem_q.rd;
        mem_wb_d.data   = ex_mem_q.mem_re ? mem_rdata : ex_mem_q.result;

        if (!resetpc) begin
            pc_d     = 32'b0;
            if_id_d  = '0;
            id_ex_d  = '0;
            ex_mem_d = '0;
            mem_wb_d = '0;
        end else if (ex_take) begin
            pc_d    = {{(32-ADDR_W){1'b0}}, br_target};
            if_id_d = '0;
            id_ex_d = '0;
        end else if (load_use) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
            id_ex_d = '0;
        end
    end

    // PC and pipeline registers; reset turns every stage into a bubble at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 32'b0;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign dbg_pc      = pc_q;
    assign dbg_wb_we   = mem_wb_q.reg_we;
    assign dbg_wb_rd   = mem_wb_q.rd;
    assign dbg_wb_data = mem_wb_q.data;

endmodule

// File: tb/tb_top_module_pipe.sv
// tb/tb_top_module_pipe.sv - table-driven bench for the five-stage pipeline
module tb_top_module_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        resetpc = 1'b0;
    logic        we0 = 1'b0;
    logic [8:0]  wr_addr0 = '0;
    logic [31:0] wr_din0 = '0;
    logic [31:0] dbg_pc;
    logic        dbg_wb_we;
    logic [4:0]  dbg_wb_rd;
    logic [31:0] dbg_wb_data;

    top_module_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .resetpc     (resetpc),
        .we0         (we0),
        .wr_addr0    (wr_addr0),
        .wr_din0     (wr_din0),
        .dbg_pc      (dbg_pc),
        .dbg_wb_we   (dbg_wb_we),
        .dbg_wb_rd   (dbg_wb_rd),
        .dbg_wb_data (dbg_wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          prog;
        int          cyc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_pc;
        logic [31:0] pc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] progs [8][12];
    int          n_vec = 0;
    int          n_miss = 0;

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    task automatic add(input int p, input int c, input logic we, input int rd, input logic [31:0] data,
                       input logic chk_pc, input logic [31:0] pc);
        vec_t v;
        v.prog = p; v.cyc = c; v.we = we; v.rd = rd[4:0]; v.data = data; v.chk_pc = chk_pc; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, load the whole instruction memory, idle with resetpc low, then release the run enable
    task automatic load_prog(input int p);
        @(negedge clk);
        reset   = 1'b1;
        resetpc = 1'b0;
        for (int i = 0; i < 128; i++) begin
            we0      = 1'b1;
            wr_addr0 = 9'(i * 4);
            wr_din0  = (i < 12) ? progs[p][i] : 32'h0;
            @(negedge clk);
        end
        we0   = 1'b0;
        reset = 1'b0;
        step();
        step();
        check($sformatf("p%0d hold pc", p), dbg_pc, 32'h0);
        check($sformatf("p%0d hold wb_we", p), {31'b0, dbg_wb_we}, 32'h0);
        resetpc = 1'b1;
    endtask

    initial begin
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 12; i++) progs[p][i] = 32'h0;

        // back-to-back forwarding
        progs[0][0] = enc_i(5, 0, 0, 1, 'h13);
        progs[0][1] = enc_i(7, 0, 0, 2, 'h13);
        progs[0][2] = enc_r(0, 2, 1, 0, 3);
        add(0, 1, 0, 0, 0, 1, 32'd4);
        add(0, 4, 1, 1, 32'd5, 0, 0);
        add(0, 5, 1, 2, 32'd7, 0, 0);
        add(0, 6, 1, 3, 32'd12, 0, 0);
        // store, load, load-use stall
        progs[1][0] = enc_i(64, 0, 0, 1, 'h13);
        progs[1][1] = enc_s(0, 1, 0);
        progs[1][2] = enc_i(0, 0, 2, 2, 'h03);
        progs[1][3] = enc_i(1, 2, 0, 3, 'h13);
        add(1, 4, 1, 1, 32'd64, 1, 32'd16);
        add(1, 5, 0, 0, 0, 1, 32'd16);
        add(1, 6, 1, 2, 32'd64, 1, 32'd20);
        add(1, 7, 0, 0, 0, 0, 0);
        add(1, 8, 1, 3, 32'd65, 0, 0);
        // taken BEQ skips one instruction
        progs[2][0] = enc_i(1, 0, 0, 1, 'h13);
        progs[2][1] = enc_b(8, 1, 1, 0);
        progs[2][2] = enc_i(9, 0, 0, 2, 'h13);
        progs[2][3] = enc_i(3, 0, 0, 4, 'h13);
        add(2, 4, 1, 1, 32'd1, 1, 32'd12);
        add(2, 5, 0, 0, 0, 0, 0);
        add(2, 6, 0, 0, 0, 0, 0);
        add(2, 7, 0, 0, 0, 0, 0);
        add(2, 8, 1, 4, 32'd3, 0, 0);
        // JAL link and two bubbles
        progs[3][0] = enc_j(12, 5);
        progs[3][1] = enc_i(8, 0, 0, 8, 'h13);
        progs[3][2] = enc_i(9, 0, 0, 9, 'h13);
        progs[3][3] = enc_i(7, 0, 0, 7, 'h13);
        add(3, 3, 0, 0, 0, 1, 32'd12);
        add(3, 4, 1, 5, 32'd4, 0, 0);
        add(3, 5, 0, 0, 0, 0, 0);
        add(3, 6, 0, 0, 0, 0, 0);
        add(3, 7, 1, 7, 32'd7, 0, 0);
        // x0 is never forwarded or written
        progs[4][0] = enc_i(5, 0, 0, 0, 'h13);
        progs[4][1] = enc_r(0, 0, 0, 0, 6);
        add(4, 5, 1, 6, 32'd0, 0, 0);
        // ALU coverage, all back-to-back
        progs[5][0]  = enc_u('h80000, 1, 'h37);
        progs[5][1]  = enc_i(-3, 0, 0, 2, 'h13);
        progs[5][2]  = enc_i('h404, 1, 5, 3, 'h13);
        progs[5][3]  = enc_i(4, 1, 5, 4, 'h13);
        progs[5][4]  = enc_r('h20, 1, 2, 0, 5);
        progs[5][5]  = enc_r(0, 2, 1, 2, 6);
        progs[5][6]  = enc_r(0, 1, 2, 3, 7);
        progs[5][7]  = enc_r(0, 2, 1, 4, 8);
        progs[5][8]  = enc_r(0, 2, 4, 6, 9);
        progs[5][9]  = enc_r(0, 3, 2, 7, 10);
        progs[5][10] = enc_i(4, 2, 1, 11, 'h13);
        add(5, 4, 1, 1, 32'h80000000, 0, 0);
        add(5, 5, 1, 2, 32'hFFFFFFFD, 0, 0);
        add(5, 6, 1, 3, 32'hF8000000, 0, 0);
        add(5, 7, 1, 4, 32'h08000000, 0, 0);
        add(5, 8, 1, 5, 32'h7FFFFFFD, 0, 0);
        add(5, 9, 1, 6, 32'h00000001, 0, 0);
        add(5, 10, 1, 7, 32'h00000000, 0, 0);
        add(5, 11, 1, 8, 32'h7FFFFFFD, 0, 0);
        add(5, 12, 1, 9, 32'hFFFFFFFD, 0, 0);
        add(5, 13, 1, 10, 32'hF8000000, 0, 0);
        add(5, 14, 1, 11, 32'hFFFFFFD0, 0, 0);
        // BLT and BGE taken, BNE not taken
        progs[6][0] = enc_i(-1, 0, 0, 1, 'h13);
        progs[6][1] = enc_b(8, 0, 1, 4);
        progs[6][2] = enc_i(1, 0, 0, 2, 'h13);
        progs[6][3] = enc_b(8, 1, 0, 5);
        progs[6][4] = enc_i(3, 0, 0, 3, 'h13);
        progs[6][5] = enc_b(8, 1, 1, 1);
        progs[6][6] = enc_i(4, 0, 0, 4, 'h13);
        add(6, 4, 1, 1, 32'hFFFFFFFF, 1, 32'd12);
        add(6, 6, 0, 0, 0, 0, 0);
        add(6, 7, 0, 0, 0, 1, 32'd20);
        add(6, 9, 0, 0, 0, 0, 0);
        add(6, 11, 0, 0, 0, 0, 0);
        add(6, 12, 1, 4, 32'd4, 0, 0);

        for (int p = 0; p < 7; p++) begin
            load_prog(p);
            for (int c = 1; c <= 16; c++) begin
                step();
                foreach (vecs[k]) begin
                    if (vecs[k].prog == p && vecs[k].cyc == c) begin
                        check($sformatf("p%0d c%0d wb_we", p, c), {31'b0, dbg_wb_we}, {31'b0, vecs[k].we});
                        if (vecs[k].we) begin
                            check($sformatf("p%0d c%0d wb_rd", p, c), {27'b0, dbg_wb_rd}, {27'b0, vecs[k].rd});
                            check($sformatf("p%0d c%0d wb_data", p, c), dbg_wb_data, vecs[k].data);
                        end
                        if (vecs[k].chk_pc)
                            check($sformatf("p%0d c%0d pc", p, c), dbg_pc, vecs[k].pc);
                    end
                end
                if (dbg_wb_we && p == 2 && dbg_wb_rd == 5'd2)
                    check("p2 x2 skipped", {27'b0, dbg_wb_rd}, 32'h0);
            end
        end

        // Instruction write while running is fetched on the next cycle
        load_prog(7);
        step();
        step();
        we0      = 1'b1;
        wr_addr0 = 9'd12;
        wr_din0  = enc_i(11, 0, 0, 11, 'h13);
        step();
        we0 = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            step();
            if (c == 6) check("live write c6 wb_we", {31'b0, dbg_wb_we}, 32'h0);
        end
        check("live write wb_we", {31'b0, dbg_wb_we}, 32'h1);
        check("live write wb_rd", {27'b0, dbg_wb_rd}, 32'd11);
        check("live write wb_data", dbg_wb_data, 32'd11);

        // Reset mid-program aborts at once, then the program reruns from 0
        load_prog(0);
        for (int c = 1; c <= 5; c++) step();
        check("pre-reset wb_rd", {27'b0, dbg_wb_rd}, 32'd2);
        check("pre-reset pc", dbg_pc, 32'd20);
        reset = 1'b1;
        #1;
        check("async reset pc", dbg_pc, 32'h0);
        check("async reset wb_we", {31'b0, dbg_wb_we}, 32'h0);
        step();
        check("held reset wb_we", {31'b0, dbg_wb_we}, 32'h0);
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) check("rerun c1 pc", dbg_pc, 32'd4);
            if (c == 4) check("rerun c4 wb_data", dbg_wb_data, 32'd5);
        end
        check("rerun c6 wb_we", {31'b0, dbg_wb_we}, 32'h1);
        check("rerun c6 wb_rd", {27'b0, dbg_wb_rd}, 32'd3);
        check("rerun c6 wb_data", dbg_wb_data, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
